// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_t;

    localparam int MAX_CH              = 16;
    localparam int DEFAULT_DIV_100M_1M = 99;

    function automatic int ch_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: idle/run FSM, period counter, divisor with shadow
// register, and registered tick/square outputs for the counter's next value.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_DIV_100M_1M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    ch_state_t        state, state_nx;
    logic [DIV_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [DIV_W-1:0] div, div_nx, shadow;
    logic [DIV_W:0]   half;
    logic             pending_nx, tick_nx, sq_nx;

    // High-phase length ceil(P/2) with P = div+1, one bit wider to avoid overflow.
    assign half    = ({1'b0, div} + (DIV_W+1)'(2)) >> 1;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nx   = state;
        cnt_nx     = '0;
        div_nx     = div;
        pending_nx = pending;
        tick_nx    = 1'b0;
        sq_nx      = 1'b0;
        case (state)
            CH_IDLE: begin
                if (pending) begin
                    div_nx     = shadow;
                    pending_nx = 1'b0;
                end
                if (en) begin
                    state_nx = CH_RUN;
                    tick_nx  = (div_nx == '0);
                    sq_nx    = 1'b1;
                end
            end
            CH_RUN: begin
                if (!en) begin
                    state_nx = CH_IDLE;
                end else if (sync || cnt == div) begin
                    if (pending) begin
                        div_nx     = shadow;
                        pending_nx = 1'b0;
                    end
                    tick_nx = (div_nx == '0);
                    sq_nx   = 1'b1;
                end else begin
                    cnt_nx  = cnt_inc;
                    tick_nx = (cnt_inc == div);
                    sq_nx   = ({1'b0, cnt_inc} < half);
                end
            end
            default: state_nx = CH_IDLE;
        endcase
        // Accept only happens while not pending, so it never collides with an apply.
        if (we) pending_nx = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CH_IDLE;
            cnt     <= '0;
            div     <= DIV_W'(DEFAULT_DIV);
            shadow  <= DIV_W'(DEFAULT_DIV);
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div     <= div_nx;
            pending <= pending_nx;
            tick    <= tick_nx;
            sq      <= sq_nx;
            if (we) shadow <= wdata;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider with valid/ready divisor load.
// Define CLK_DIV_SYNC_EN to add sync_i, which phase-aligns all running channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_100M_1M,
    localparam int CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_i,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DIV_W-1:0]  load_div,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o,
    output logic [NUM_CH-1:0] pending_o
);

    logic [NUM_CH-1:0] we;
    logic              sync;

`ifdef CLK_DIV_SYNC_EN
    assign sync = sync_i;
`else
    assign sync = 1'b0;
`endif

    // Out-of-range channel indices match no channel: ready stays 1, write dropped.
    always_comb begin
        load_ready = 1'b1;
        we         = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (load_ch == CH_W'(i)) begin
                load_ready = ~pending_o[i];
                we[i]      = load_valid & ~pending_o[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[g]),
            .sync    (sync),
            .we      (we[g]),
            .wdata   (load_div),
            .tick    (tick_o[g]),
            .sq      (sq_o[g]),
            .pending (pending_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: period-level reference model plus
// directed literal checks; covers sync_i when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int DW  = 4;
    localparam int DD  = 3;
    localparam int CW  = 2;

    logic           clk = 0;
    logic           rst = 1;
    logic           sync = 0;
    logic [NCH-1:0] ch_en = '0;
    logic           load_valid = 0;
    logic           load_ready;
    logic [CW-1:0]  load_ch = '0;
    logic [DW-1:0]  load_div = '0;
    logic [NCH-1:0] tick_o, sq_o, pending_o;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    // Model: per channel, running flag, position in period, divisor, shadow.
    bit m_run [NCH];
    int m_c   [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_pend[NCH];

    bit pat_sq4 [4] = '{1, 1, 0, 0};
    bit pat_tk4 [4] = '{0, 0, 0, 1};
    bit pat_sq5 [5] = '{1, 1, 1, 0, 0};
    bit pat_tk5 [5] = '{0, 0, 0, 0, 1};

    clk_div_multi #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync_i     (sync),
`endif
        .ch_en      (ch_en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_ch    (load_ch),
        .load_div   (load_div),
        .tick_o     (tick_o),
        .sq_o       (sq_o),
        .pending_o  (pending_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        bit acc;
        int p;
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_run[i] = 0; m_c[i] = 0; m_div[i] = DD; m_sh[i] = DD; m_pend[i] = 0;
            end else begin
                acc = load_valid && (int'(load_ch) == i) && !m_pend[i];
                p   = m_div[i] + 1;
                if (!m_run[i]) begin
                    if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
                    if (ch_en[i]) begin m_run[i] = 1; m_c[i] = 0; end
                end else if (!ch_en[i]) begin
                    m_run[i] = 0; m_c[i] = 0;
                end else if (sync || m_c[i] + 1 == p) begin
                    m_c[i] = 0;
                    if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
                end else begin
                    m_c[i] = m_c[i] + 1;
                end
                if (acc) begin m_sh[i] = int'(load_div); m_pend[i] = 1; end
            end
        end
    end

    always @(negedge clk) begin
        int p;
        bit exp_rdy;
        if (chk_on) begin
            for (int i = 0; i < NCH; i++) begin
                p = m_div[i] + 1;
                chk($sformatf("tick%0d", i), 32'(tick_o[i]), 32'(m_run[i] && (m_c[i] == p - 1)));
                chk($sformatf("sq%0d", i), 32'(sq_o[i]), 32'(m_run[i] && (2 * m_c[i] < p)));
                chk($sformatf("pend%0d", i), 32'(pending_o[i]), 32'(m_pend[i]));
            end
            if (int'(load_ch) >= NCH) exp_rdy = 1;
            else exp_rdy = !m_pend[int'(load_ch)];
            chk("load_ready", 32'(load_ready), 32'(exp_rdy));
        end
    end

    initial begin
        bit done;
        // Reset state
        cyc(); cyc(); cyc();
        chk_on = 1;
        chk("rst_tick", 32'(tick_o), 0);
        chk("rst_sq", 32'(sq_o), 0);
        chk("rst_pend", 32'(pending_o), 0);
        chk("rst_ready", 32'(load_ready), 1);
        rst = 0;

        // ch0 at D=3: first high in the cycle after ch_en is sampled
        ch_en = 3'b001;
        cyc();
        for (int k = 0; k < 8; k++) begin
            chk("d1_sq0", 32'(sq_o[0]), 32'(pat_sq4[k % 4]));
            chk("d1_tk0", 32'(tick_o[0]), 32'(pat_tk4[k % 4]));
            cyc();
        end

        // Load D=4 to running ch1; second load stalls until the wrap
        ch_en = 3'b011;
        cyc(); cyc(); cyc();
        load_valid = 1; load_ch = 1; load_div = 4;
        cyc();
        chk("d2_pend1", 32'(pending_o[1]), 1);
        load_div = 7;
        #1 chk("d2_ready", 32'(load_ready), 0);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            cyc();
            if (!pending_o[1]) done = 1;
        end
        chk("d2_wait_apply", 32'(done), 1);
        load_valid = 0;
        for (int k = 0; k < 5; k++) begin
            chk("d2_sq1", 32'(sq_o[1]), 32'(pat_sq5[k]));
            chk("d2_tk1", 32'(tick_o[1]), 32'(pat_tk5[k]));
            cyc();
        end
        chk("d2_dropped", 32'(pending_o[1]), 0);

        // D=0 on ch2, enabled as the pending divisor applies
        load_valid = 1; load_ch = 2; load_div = 0;
        cyc();
        load_valid = 0; ch_en[2] = 1;
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("d3_tk2", 32'(tick_o[2]), 1);
            chk("d3_sq2", 32'(sq_o[2]), 1);
            cyc();
        end
        ch_en[2] = 0;
        cyc();
        chk("d3_off_tk2", 32'(tick_o[2]), 0);
        chk("d3_off_sq2", 32'(sq_o[2]), 0);

        // Load accepted on ch0's wrap edge: old period once more, then D=1
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (tick_o[0]) done = 1;
            else cyc();
        end
        chk("d4_wait_tick", 32'(done), 1);
        load_valid = 1; load_ch = 0; load_div = 1;
        cyc();
        load_valid = 0;
        for (int k = 0; k < 4; k++) begin
            chk("d4_old_sq0", 32'(sq_o[0]), 32'(pat_sq4[k]));
            chk("d4_old_tk0", 32'(tick_o[0]), 32'(pat_tk4[k]));
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            chk("d4_new_sq0", 32'(sq_o[0]), 32'(k == 0));
            chk("d4_new_tk0", 32'(tick_o[0]), 32'(k == 1));
            cyc();
        end

        // Out-of-range channel: accepted-looking, no effect
        load_valid = 1; load_ch = 3; load_div = 9;
        #1 chk("d4_oor_ready", 32'(load_ready), 1);
        cyc();
        chk("d4_oor_pend", 32'(pending_o), 0);
        load_valid = 0; load_ch = 0;

        // Reset mid-period with a pending load
        load_valid = 1; load_ch = 0; load_div = 9;
        cyc();
        load_valid = 0;
        chk("d5_pend0", 32'(pending_o[0]), 1);
        rst = 1;
        cyc();
        chk("d5_tick", 32'(tick_o), 0);
        chk("d5_sq", 32'(sq_o), 0);
        chk("d5_pend", 32'(pending_o), 0);
        #1 chk("d5_ready", 32'(load_ready), 1);
        rst = 0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("d5_sq0", 32'(sq_o[0]), 32'(pat_sq4[k]));
            chk("d5_tk0", 32'(tick_o[0]), 32'(pat_tk4[k]));
            cyc();
        end

        // Largest period: D=2^DW-1 gives P=16 without counter overflow
        ch_en = '0;
        cyc();
        load_valid = 1; load_ch = 1; load_div = 15;
        cyc();
        load_valid = 0; ch_en = 3'b010;
        cyc();
        for (int k = 0; k < 16; k++) begin
            chk("d6_sq1", 32'(sq_o[1]), 32'(k < 8));
            chk("d6_tk1", 32'(tick_o[1]), 32'(k == 15));
            cyc();
        end

`ifdef CLK_DIV_SYNC_EN
        // Phase-align ch0 (D=3) and ch1 (D=5)
        ch_en = 3'b011;
        load_valid = 1; load_ch = 1; load_div = 5;
        cyc();
        load_valid = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            cyc();
            if (!pending_o[1]) done = 1;
        end
        chk("s_wait_apply", 32'(done), 1);
        repeat (3 + $urandom_range(0, 7)) cyc();
        sync = 1;
        cyc();
        sync = 0;
        chk("s_sq0", 32'(sq_o[0]), 1);
        chk("s_sq1", 32'(sq_o[1]), 1);
        repeat (11) cyc();
        chk("s_tk0", 32'(tick_o[0]), 1);
        chk("s_tk1", 32'(tick_o[1]), 1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int j;
            if ($urandom_range(0, 15) == 0) begin
                j = $urandom_range(0, NCH - 1);
                ch_en[j] = ~ch_en[j];
            end
            load_valid = ($urandom_range(0, 3) == 0);
            load_ch    = CW'($urandom_range(0, 3));
            load_div   = ($urandom_range(0, 7) == 0) ? DW'(15) : DW'($urandom_range(0, 6));
            rst        = ($urandom_range(0, 199) == 0);
`ifdef CLK_DIV_SYNC_EN
            sync       = ($urandom_range(0, 19) == 0);
`endif
            cyc();
        end
        rst = 0; sync = 0; load_valid = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
